// File: rtl/mul_operand_collector_if.sv
// Handshake bundle between the router ejection port, the operand collector and the multiplier.
// master = collector side, slave = router/multiplier side.
interface mul_operand_collector_if #(
    parameter int FLIT_W = 71,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
);
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              op_ready;
    logic [CNT_W-1:0]  dup_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        input  in_flit,
        input  in_valid,
        output in_ready,
        output op_a,
        output op_b,
        output op_valid,
        input  op_ready,
        output dup_cnt,
        output drop_cnt
    );

    modport slave (
        output in_flit,
        output in_valid,
        input  in_ready,
        input  op_a,
        input  op_b,
        input  op_valid,
        output op_ready,
        input  dup_cnt,
        input  drop_cnt
    );
endinterface

// File: rtl/mul_operand_collector.sv
// Pairs operand A (tag 0) and operand B (tag 1) flits from the router into {A,B} for the multiplier.
// Optional feature macro OPCOL_DEST_CHECK_EN: drop valid flits whose dest field differs from LOCAL_ID.
module mul_operand_collector #(
    parameter int         FLIT_W   = 71,
    parameter int         DATA_W   = 64,
    parameter int         CNT_W    = 8,
    parameter logic [3:0] LOCAL_ID = 4'b0001
) (
    input  logic                    clk,
    input  logic                    rst,
    mul_operand_collector_if.master bus
);

    localparam int TAG_BIT  = DATA_W;
    localparam int DEST_LO  = DATA_W + 1;
    localparam int DEST_HI  = DATA_W + 4;
    localparam int TAIL_BIT = DATA_W + 5;
    localparam int VLD_BIT  = DATA_W + 6;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HAVE_A = 2'd1,
        ST_HAVE_B = 2'd2,
        ST_PAIR   = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + one;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic              op_valid_r;
    logic [CNT_W-1:0]  dup_cnt_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              flit_vld_s;
    logic              tag_s;
    logic              dest_ok_s;
    logic              take_s;
    logic              wr_a_s;
    logic              wr_b_s;
    logic              dup_s;
    logic              unused_s;

    // Flit field decode and accept qualification; in_ready depends on state only
    assign in_ready_s = (state_r != ST_PAIR);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign flit_vld_s = bus.in_flit[VLD_BIT];
    assign tag_s      = bus.in_flit[TAG_BIT];

`ifdef OPCOL_DEST_CHECK_EN
    logic             drop_s;
    logic [CNT_W-1:0] drop_cnt_r;

    assign dest_ok_s = (bus.in_flit[DEST_HI:DEST_LO] == LOCAL_ID);
    assign drop_s    = accept_s & flit_vld_s & ~dest_ok_s;

    // Drop counter: misaddressed flits, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign bus.drop_cnt = drop_cnt_r;
`else
    assign dest_ok_s    = 1'b1;
    assign bus.drop_cnt = {CNT_W{1'b0}};
`endif

    // Tail is meaningless for single-flit packets; dest/ID only matter with the check enabled
    assign unused_s = ^{bus.in_flit[TAIL_BIT], bus.in_flit[DEST_HI:DEST_LO], LOCAL_ID};

    // A bubble (flit valid bit clear) is accepted but never reaches the FSM
    assign take_s = accept_s & flit_vld_s & dest_ok_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (take_s) begin
                    state_next_s = tag_s ? ST_HAVE_B : ST_HAVE_A;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_HAVE_A: begin
                if (take_s && tag_s) begin
                    state_next_s = ST_PAIR;
                end else begin
                    state_next_s = ST_HAVE_A;
                end
            end
            ST_HAVE_B: begin
                if (take_s && !tag_s) begin
                    state_next_s = ST_PAIR;
                end else begin
                    state_next_s = ST_HAVE_B;
                end
            end
            ST_PAIR: begin
                if (bus.op_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_PAIR;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Output decode: operand write strobes and duplicate detection
    always_comb begin
        wr_a_s = 1'b0;
        wr_b_s = 1'b0;
        dup_s  = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                wr_a_s = take_s & ~tag_s;
                wr_b_s = take_s &  tag_s;
            end
            ST_HAVE_A: begin
                wr_a_s = take_s & ~tag_s;
                wr_b_s = take_s &  tag_s;
                dup_s  = take_s & ~tag_s;
            end
            ST_HAVE_B: begin
                wr_a_s = take_s & ~tag_s;
                wr_b_s = take_s &  tag_s;
                dup_s  = take_s &  tag_s;
            end
            ST_PAIR: begin
                wr_a_s = 1'b0;
                wr_b_s = 1'b0;
                dup_s  = 1'b0;
            end
            default: begin
                wr_a_s = 1'b0;
                wr_b_s = 1'b0;
                dup_s  = 1'b0;
            end
        endcase
    end

    // Operand registers; held untouched while the pair waits for the multiplier
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r <= {DATA_W{1'b0}};
            op_b_r <= {DATA_W{1'b0}};
        end else begin
            if (wr_a_s) begin
                op_a_r <= bus.in_flit[DATA_W-1:0];
            end else begin
                op_a_r <= op_a_r;
            end
            if (wr_b_s) begin
                op_b_r <= bus.in_flit[DATA_W-1:0];
            end else begin
                op_b_r <= op_b_r;
            end
        end
    end

    // op_valid tracks the PAIR state, registered alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_r <= 1'b0;
        end else begin
            op_valid_r <= (state_next_s == ST_PAIR);
        end
    end

    // Duplicate counter: same-tag overwrite of a held operand, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            dup_cnt_r <= {CNT_W{1'b0}};
        end else if (dup_s) begin
            dup_cnt_r <= sat_inc(dup_cnt_r);
        end else begin
            dup_cnt_r <= dup_cnt_r;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.op_a     = op_a_r;
    assign bus.op_b     = op_b_r;
    assign bus.op_valid = op_valid_r;
    assign bus.dup_cnt  = dup_cnt_r;

endmodule
